// File: rtl/rotary_cells_pkg.sv
// Shared types and constants for the rotary_cells valve sequencer.
package rotary_cells_pkg;

    typedef enum logic [1:0] {
        OP_LOAD     = 2'd0,
        OP_MIX      = 2'd1,
        OP_DISPENSE = 2'd2,
        OP_RSVD     = 2'd3
    } op_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_PUMP    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // {cb3_1,cb3_2,cb3_3} per peristaltic phase; entry 0 is the first phase.
    localparam logic [5:0][2:0] PHASE_PAT = {3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    localparam int V_CB1_1 = 12;
    localparam int V_CB1_2 = 11;
    localparam int V_CB2_1 = 10;
    localparam int V_CB2_2 = 9;
    localparam int V_CB3_1 = 8;
    localparam int V_CB3_2 = 7;
    localparam int V_CB3_3 = 6;
    localparam int V_CB4_1 = 5;
    localparam int V_CB4_2 = 4;
    localparam int V_CB5_1 = 3;
    localparam int V_CB5_2 = 2;
    localparam int V_CB6_1 = 1;
    localparam int V_CB6_2 = 0;

    // Routing valves for an op; mixer pump valves are left closed.
    function automatic logic [12:0] route_vec(input op_e op, input logic [1:0] port);
        logic [12:0] v;
        v = '1;
        case (op)
            OP_LOAD: begin
                v[V_CB1_1] = port[0];
                v[V_CB1_2] = ~port[0];
                v[V_CB2_1] = port[1];
                v[V_CB2_2] = ~port[1];
                v[V_CB4_1] = 1'b0;
            end
            OP_DISPENSE: begin
                v[V_CB5_1] = port[0];
                v[V_CB5_2] = ~port[0];
                v[V_CB6_1] = port[1];
                v[V_CB6_2] = ~port[1];
                v[V_CB4_2] = 1'b0;
            end
            default: v = '1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rotary_cells_ctrl_peristaltic_seq.sv
// Peristaltic phase generator: holds each of 6 phases PHASE_CYC cycles, pulses rot_tick on the last cycle of phase 5.
// pat_next is the pattern for the coming cycle so the parent can register it alongside its other valves.
module peristaltic_seq
    import rotary_cells_pkg::*;
#(
    parameter int PHASE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       run,
    output logic       rot_tick,
    output logic [2:0] pat_next
);
    localparam int HW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;

    logic [HW-1:0] hold_q, hold_d;
    logic [2:0]    phase_q, phase_d;
    logic          wrap;

    assign wrap     = (hold_q == HW'(PHASE_CYC - 1));
    assign rot_tick = en && wrap && (phase_q == 3'd5);

    // run without en is the first pumping cycle: start from phase 0.
    always_comb begin
        hold_d  = '0;
        phase_d = '0;
        if (run && en) begin
            if (wrap) begin
                phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
            end else begin
                hold_d  = hold_q + 1'b1;
                phase_d = phase_q;
            end
        end
        pat_next = run ? PHASE_PAT[phase_d] : 3'b111;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q  <= '0;
            phase_q <= '0;
        end else begin
            hold_q  <= hold_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/rotary_cells_ctrl.sv
// Command sequencer for the 13 rotary_cells control lines: routing setup, peristaltic pumping, release.
// Accepts one command at a time; cmd_ready only in IDLE, valve outputs all registered and default closed.
module rotary_cells_ctrl
    import rotary_cells_pkg::*;
#(
    parameter int PHASE_CYC  = 4,
    parameter int SETTLE_CYC = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_port,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             cb1_1, cb1_2, cb2_1, cb2_2,
    output logic             cb3_1, cb3_2, cb3_3,
    output logic             cb4_1, cb4_2,
    output logic             cb5_1, cb5_2, cb6_1, cb6_2
);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0] rot_q, rot_d;
    op_e              op_q, op_sel;
    logic [1:0]       port_q, port_sel;
    logic [12:0]      valves_q, valves_d;
    logic             done_q, err_q;
    logic             accept, settle_end, rot_tick;
    logic [2:0]       pat_next;

    assign cmd_ready  = rst_n && (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign settle_end = (settle_q == SW'(SETTLE_CYC - 1));
    assign op_sel     = accept ? op_e'(cmd_op) : op_q;
    assign port_sel   = accept ? cmd_port : port_q;

    peristaltic_seq #(.PHASE_CYC(PHASE_CYC)) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state_q == ST_PUMP),
        .run      (state_d == ST_PUMP),
        .rot_tick (rot_tick),
        .pat_next (pat_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && op_e'(cmd_op) != OP_RSVD) state_d = ST_SETUP;
            ST_SETUP: if (settle_end) state_d = (rot_q == '0) ? ST_RELEASE : ST_PUMP;
            ST_PUMP:  if (rot_tick && rot_q == CNT_W'(1)) state_d = ST_RELEASE;
            default:  if (settle_end) state_d = ST_IDLE;
        endcase

        settle_d = '0;
        if ((state_q == ST_SETUP || state_q == ST_RELEASE) && state_d == state_q)
            settle_d = settle_q + 1'b1;

        rot_d = rot_q;
        if (accept)
            rot_d = cmd_count;
        else if (state_q == ST_PUMP && rot_tick)
            rot_d = rot_q - 1'b1;

        // Valves are decoded from the next state so they change on the same edge as the FSM.
        valves_d = '1;
        if (state_d == ST_SETUP || state_d == ST_PUMP)
            valves_d = route_vec(op_sel, port_sel);
        valves_d[V_CB3_1] = pat_next[2];
        valves_d[V_CB3_2] = pat_next[1];
        valves_d[V_CB3_3] = pat_next[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            rot_q    <= '0;
            op_q     <= OP_LOAD;
            port_q   <= '0;
            valves_q <= '1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            rot_q    <= rot_d;
            op_q     <= op_sel;
            port_q   <= port_sel;
            valves_q <= valves_d;
            done_q   <= (state_q == ST_RELEASE) && (state_d == ST_IDLE);
            err_q    <= accept && (op_e'(cmd_op) == OP_RSVD);
        end
    end

    assign done  = done_q;
    assign err   = err_q;
    assign cb1_1 = valves_q[V_CB1_1];
    assign cb1_2 = valves_q[V_CB1_2];
    assign cb2_1 = valves_q[V_CB2_1];
    assign cb2_2 = valves_q[V_CB2_2];
    assign cb3_1 = valves_q[V_CB3_1];
    assign cb3_2 = valves_q[V_CB3_2];
    assign cb3_3 = valves_q[V_CB3_3];
    assign cb4_1 = valves_q[V_CB4_1];
    assign cb4_2 = valves_q[V_CB4_2];
    assign cb5_1 = valves_q[V_CB5_1];
    assign cb5_2 = valves_q[V_CB5_2];
    assign cb6_1 = valves_q[V_CB6_1];
    assign cb6_2 = valves_q[V_CB6_2];

endmodule

// File: doc/rotary_cells_ctrl.md
# rotary_cells_ctrl

Sequencer that drives the 13 pneumatic control lines of the `rotary_cells` chip: the inlet mux `m1`, the rotary-mixer valves, and the trap-select mux `m2`. It accepts load, mix and dispense commands over a valid/ready handshake and steps the valves through routing setup, peristaltic pumping and release. It sits between the host command FIFO and the solenoid driver board; each output bit maps 1:1 to one chip control port.

## Interface
- `PHASE_CYC`, 4: clock cycles each peristaltic phase is held (≥1)
- `SETTLE_CYC`, 8: clock cycles of valve settle in SETUP and RELEASE (≥1)
- `CNT_W`, 16: width of the rotation count
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block idle and able to accept
- `cmd_op`  in  2  0 LOAD, 1 MIX, 2 DISPENSE, 3 reserved
- `cmd_port`  in  2  LOAD: inlet pb1_1..pb1_4 (0..3); DISPENSE: trap b1_1..b1_4 (0..3); ignored for MIX
- `cmd_count`  in  CNT_W  full pump rotations (6 phases each)
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse on command completion
- `err`  out  1  one-cycle pulse when a reserved op is accepted
- `cb1_1, cb1_2, cb2_1, cb2_2`  out  1 each  m1 address lines
- `cb3_1, cb3_2, cb3_3`  out  1 each  mixer peristaltic valves
- `cb4_1, cb4_2`  out  1 each  mixer inlet / outlet isolation
- `cb5_1, cb5_2, cb6_1, cb6_2`  out  1 each  m2 address lines

## Operation
- Valve polarity: 1 = pressurised (closed). Every valve output is registered and resets to 1.
- Handshake: transfer on the edge where `cmd_valid && cmd_ready`. `cmd_ready = (state==IDLE)`, forced 0 while `rst_n` low. Command fields are latched at transfer.
- States: IDLE → SETUP → PUMP → RELEASE → IDLE. Op 3: IDLE → IDLE, `err` pulses the next cycle, no valve changes, no `done`.
- SETUP (SETTLE_CYC cycles): routing valves driven, `cb3_*` = 111.
  - LOAD: m1 addressed by `cmd_port` as `cb1_1=p[0]`, `cb1_2=~p[0]`, `cb2_1=p[1]`, `cb2_2=~p[1]`; `cb4_1=0`, `cb4_2=1`; m2 lines all 1.
  - MIX: `cb4_1=cb4_2=1`; m1 and m2 lines all 1.
  - DISPENSE: m2 addressed by `cmd_port` as `cb5_1=p[0]`, `cb5_2=~p[0]`, `cb6_1=p[1]`, `cb6_2=~p[1]`; `cb4_1=1`, `cb4_2=0`; m1 lines all 1.
- PUMP: routing held. `{cb3_1,cb3_2,cb3_3}` cycles through phases 0..5 = 101, 100, 110, 010, 011, 001. Each phase is held PHASE_CYC cycles. The rotation counter decrements after phase 5. Exit when it reaches 0. `cmd_count==0` skips PUMP: SETUP goes directly to RELEASE.
- RELEASE (SETTLE_CYC cycles): all 13 outputs = 1.
- `done` pulses in the first IDLE cycle after RELEASE. A new command may be accepted in that same cycle.
- `cmd_valid` while busy is ignored; the command is not dropped, it simply waits for ready.
- Reset mid-operation: on the first edge with `rst_n` low, the block returns to IDLE, all valves go to 1, counters clear, and `done`/`err` are 0. No completion is reported.

## Timing
- Transfer at edge E0. Outputs reflect SETUP from cycle E0+1.
- PUMP starts at E0+1+SETTLE_CYC. RELEASE starts at E0+1+SETTLE_CYC+6·PHASE_CYC·N.
- `done` is high in cycle E0+1+2·SETTLE_CYC+6·PHASE_CYC·N.
- Counters are CNT_W wide. The phase counter is ⌈log2 PHASE_CYC⌉ bits and wraps at PHASE_CYC−1. There is no overflow path.
- `busy` equals `!cmd_ready` outside reset.

## Structure
- `rotary_cells_pkg`: op enum, state enum, 6-entry phase pattern constant, valve-vector field indices.
- Sub-module `peristaltic_seq`: enable, phase-hold counter, 3-bit pattern output, and a `rot_tick` pulse after phase 5. The top level holds the FSM, rotation counter and routing decode.

## Test plan
- Reset (PHASE_CYC=4, SETTLE_CYC=8) → all 13 valves =1, `cmd_ready`=0 during reset and 1 the cycle after release, `done`=`err`=0.
- LOAD port 2, count 1 → `cb1_1..cb2_2`=0,1,1,0; `cb4_1`=0; pump sequence 101…001, each held 4 cycles; `done` at E0+41; all valves 1 by then.
- MIX count 3 → `cb4_*`=11 throughout; 18 phases seen; `done` at E0+89.
- DISPENSE port 3, count 0 → `cb5_1..cb6_2`=1,0,1,0 for 8 cycles, no pump motion, `done` at E0+17.
- Op 3 → `err` at E0+1, no valve change, `cmd_ready` stays 1; `cmd_valid` held during a busy MIX is accepted exactly at its `done` cycle.
- `rst_n` low in mid-PUMP of LOAD count 5 → all valves 1 next edge, no `done`; a following MIX runs normally.
